// File: rtl/game_ctrl_fsm.sv
// Match controller for the pong game: debounces the start/pause buttons, sequences
// IDLE/SERVE/PLAY/PAUSE/OVER from the ball engine's scores and drives game_state back to it.
module game_ctrl_fsm #(
    parameter int DEBOUNCE_MS = 20,
    parameter int SERVE_MS    = 1000,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       i_btn_start,
    input  logic       i_btn_pause,
    input  logic [3:0] i_p1_score,
    input  logic [3:0] i_p2_score,
    output logic [1:0] o_game_state,
    output logic       o_ball_rst_n,
    output logic       o_paused,
    output logic       o_p1_point,
    output logic       o_p2_point,
    output logic [1:0] o_winner
);

    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int SV_W = $clog2(SERVE_MS + 1);
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [SV_W-1:0] SV_RELOAD = SV_W'(SERVE_MS - 1);
    localparam logic [3:0]      WIN       = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_PAUSE,
        S_OVER
    } state_t;

    logic [1:0] w_btnRaw;
    logic [1:0] w_press;
    logic       w_startPress;
    logic       w_pausePress;

    assign w_btnRaw     = {i_btn_pause, i_btn_start};
    assign w_startPress = w_press[0];
    assign w_pausePress = w_press[1];

    // The counter only runs while the synced level disagrees with the debounced one,
    // so any return to the debounced level reloads it and short glitches never land.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_debQ;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk_1ms) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_debQ  <= 1'b0;
                r_cnt   <= DB_RELOAD;
            end else begin
                r_sync1 <= w_btnRaw[g];
                r_sync2 <= r_sync1;
                r_debQ  <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= DB_RELOAD;
                end else if (r_cnt == '0) begin
                    r_deb <= r_sync2;
                    r_cnt <= DB_RELOAD;
                end else begin
                    r_cnt <= r_cnt - DB_W'(1);
                end
            end
        end

        assign w_press[g] = r_deb & ~r_debQ;
    end

    state_t          r_state;
    state_t          w_stateNext;
    logic [SV_W-1:0] r_serveCnt;
    logic [SV_W-1:0] w_serveNext;
    logic [3:0]      r_prevP1;
    logic [3:0]      r_prevP2;
    logic [1:0]      r_gameState;
    logic [1:0]      w_gameStateNext;
    logic            r_ballRstN;
    logic            w_ballRstNNext;
    logic            r_paused;
    logic            r_p1Point;
    logic            r_p2Point;
    logic [1:0]      r_winner;
    logic [1:0]      w_winnerNext;
    logic            w_p1Pt;
    logic            w_p2Pt;
    logic            w_p1Win;
    logic            w_p2Win;

    // Only a +1 step counts as a point; clears and jumps just resync prev.
    assign w_p1Pt  = (r_state == S_PLAY) && (i_p1_score == r_prevP1 + 4'd1);
    assign w_p2Pt  = (r_state == S_PLAY) && (i_p2_score == r_prevP2 + 4'd1);
    assign w_p1Win = w_p1Pt && (i_p1_score >= WIN);
    assign w_p2Win = w_p2Pt && (i_p2_score >= WIN);

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_serveCnt  <= '0;
            r_prevP1    <= i_p1_score;
            r_prevP2    <= i_p2_score;
            r_gameState <= 2'b00;
            r_ballRstN  <= 1'b1;
            r_paused    <= 1'b0;
            r_p1Point   <= 1'b0;
            r_p2Point   <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            r_state     <= w_stateNext;
            r_serveCnt  <= w_serveNext;
            r_prevP1    <= i_p1_score;
            r_prevP2    <= i_p2_score;
            r_gameState <= w_gameStateNext;
            r_ballRstN  <= w_ballRstNNext;
            r_paused    <= (w_stateNext == S_PAUSE);
            r_p1Point   <= w_p1Pt;
            r_p2Point   <= w_p2Pt;
            r_winner    <= w_winnerNext;
        end
    end

    // Points take priority over a pause press; start is checked before pause.
    always_comb begin
        w_stateNext    = r_state;
        w_serveNext    = r_serveCnt;
        w_ballRstNNext = 1'b1;
        w_winnerNext   = r_winner;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_startPress) begin
                    w_stateNext    = S_SERVE;
                    w_serveNext    = SV_RELOAD;
                    w_ballRstNNext = 1'b0;
                    w_winnerNext   = 2'b00;
                end
            end
            S_SERVE: begin
                if (r_serveCnt == '0) begin
                    w_stateNext = S_PLAY;
                end else begin
                    w_serveNext = r_serveCnt - SV_W'(1);
                end
            end
            S_PLAY: begin
                if (w_p1Pt || w_p2Pt) begin
                    if (w_p1Win || w_p2Win) begin
                        w_stateNext  = S_OVER;
                        w_winnerNext = {w_p2Win, w_p1Win};
                    end else begin
                        w_stateNext = S_SERVE;
                        w_serveNext = SV_RELOAD;
                    end
                end else if (w_pausePress) begin
                    w_stateNext = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_startPress) begin
                    w_stateNext = S_IDLE;
                end else if (w_pausePress) begin
                    w_stateNext = S_PLAY;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase

        case (w_stateNext)
            S_IDLE:           w_gameStateNext = 2'b00;
            S_PLAY:           w_gameStateNext = 2'b01;
            S_SERVE, S_PAUSE: w_gameStateNext = 2'b10;
            default:          w_gameStateNext = 2'b11;
        endcase
    end

    assign o_game_state = r_gameState;
    assign o_ball_rst_n = r_ballRstN;
    assign o_paused     = r_paused;
    assign o_p1_point   = r_p1Point;
    assign o_p2_point   = r_p2Point;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm with short debounce/serve times; inputs change and
// outputs are sampled on the falling edge, so "k cycles later" means k rising edges.
module tb_game_ctrl_fsm;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       btnStart;
    logic       btnPause;
    logic [3:0] p1Score;
    logic [3:0] p2Score;
    logic [1:0] gameState;
    logic       ballRstN;
    logic       paused;
    logic       p1Point;
    logic       p2Point;
    logic [1:0] winner;

    int nChecks = 0;
    int nFails  = 0;

    game_ctrl_fsm #(
        .DEBOUNCE_MS(4),
        .SERVE_MS   (10),
        .WIN_SCORE  (3)
    ) dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .i_btn_start (btnStart),
        .i_btn_pause (btnPause),
        .i_p1_score  (p1Score),
        .i_p2_score  (p2Score),
        .o_game_state(gameState),
        .o_ball_rst_n(ballRstN),
        .o_paused    (paused),
        .o_p1_point  (p1Point),
        .o_p2_point  (p2Point),
        .o_winner    (winner)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds a button long enough for exactly one press; the event lands on the last tick.
    task automatic applyStimulus(input bit isPause);
        if (isPause) btnPause = 1'b1;
        else         btnStart = 1'b1;
        tick(7);
    endtask

    task automatic releaseButtons();
        btnStart = 1'b0;
        btnPause = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        btnStart = 1'b0;
        btnPause = 1'b0;
        p1Score  = 4'd0;
        p2Score  = 4'd0;
        tick(2);
        checkOutput("rst_state",  {2'b00, gameState}, 4'h0);
        checkOutput("rst_ballrst", {3'b000, ballRstN}, 4'h1);
        checkOutput("rst_winner", {2'b00, winner}, 4'h0);
        checkOutput("rst_pulses", {1'b0, paused, p1Point, p2Point}, 4'h0);
        reset = 1'b1;
        tick(1);

        btnStart = 1'b1;
        tick(3);
        btnStart = 1'b0;
        tick(8);
        checkOutput("glitch_state",   {2'b00, gameState}, 4'h0);
        checkOutput("glitch_ballrst", {3'b000, ballRstN}, 4'h1);

        btnStart = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            checkOutput($sformatf("start_ballrst_k%0d", k), {3'b000, ballRstN}, (k == 7) ? 4'h0 : 4'h1);
            checkOutput($sformatf("start_state_k%0d", k), {2'b00, gameState},
                        (k < 7) ? 4'h0 : ((k <= 16) ? 4'h2 : 4'h1));
            if (k == 10) btnStart = 1'b0;
        end

        p1Score = 4'd1;
        tick(1);
        checkOutput("p1pt_pulse", {3'b000, p1Point}, 4'h1);
        checkOutput("p1pt_state", {2'b00, gameState}, 4'h2);
        tick(1);
        checkOutput("p1pt_end", {3'b000, p1Point}, 4'h0);
        tick(8);
        checkOutput("p1pt_serve_k10", {2'b00, gameState}, 4'h2);
        tick(1);
        checkOutput("p1pt_play", {2'b00, gameState}, 4'h1);

        p2Score = 4'd5;
        tick(1);
        checkOutput("p2jump_pulse", {3'b000, p2Point}, 4'h0);
        checkOutput("p2jump_state", {2'b00, gameState}, 4'h1);
        p2Score = 4'd0;
        tick(1);
        checkOutput("p2clear_pulse", {3'b000, p2Point}, 4'h0);

        applyStimulus(1'b1);
        checkOutput("pause_state",  {2'b00, gameState}, 4'h2);
        checkOutput("pause_paused", {3'b000, paused}, 4'h1);
        releaseButtons();
        p1Score = 4'd2;
        tick(1);
        checkOutput("pause_nopoint", {3'b000, p1Point}, 4'h0);
        p1Score = 4'd1;
        tick(8);
        checkOutput("pause_held", {2'b00, gameState}, 4'h2);
        applyStimulus(1'b1);
        checkOutput("resume_state",  {2'b00, gameState}, 4'h1);
        checkOutput("resume_paused", {3'b000, paused}, 4'h0);
        releaseButtons();
        tick(8);
        applyStimulus(1'b1);
        checkOutput("pause2_state", {2'b00, gameState}, 4'h2);
        releaseButtons();
        tick(8);
        applyStimulus(1'b0);
        checkOutput("pause_start_state",   {2'b00, gameState}, 4'h0);
        checkOutput("pause_start_ballrst", {3'b000, ballRstN}, 4'h1);
        checkOutput("pause_start_paused",  {3'b000, paused}, 4'h0);
        releaseButtons();
        tick(8);

        applyStimulus(1'b0);
        checkOutput("m2_ballrst", {3'b000, ballRstN}, 4'h0);
        checkOutput("m2_state",   {2'b00, gameState}, 4'h2);
        releaseButtons();
        p1Score = 4'd0;
        p2Score = 4'd0;
        tick(10);
        checkOutput("m2_play", {2'b00, gameState}, 4'h1);
        for (int s = 1; s <= 2; s++) begin
            p2Score = 4'(s);
            tick(1);
            checkOutput($sformatf("m2_p2pt_%0d", s), {3'b000, p2Point}, 4'h1);
            tick(10);
            checkOutput($sformatf("m2_replay_%0d", s), {2'b00, gameState}, 4'h1);
        end
        p2Score = 4'd3;
        tick(1);
        checkOutput("p2win_state",  {2'b00, gameState}, 4'h3);
        checkOutput("p2win_winner", {2'b00, winner}, 4'h2);
        tick(3);
        checkOutput("p2win_hold", {2'b00, winner}, 4'h2);
        applyStimulus(1'b0);
        checkOutput("over_start_ballrst", {3'b000, ballRstN}, 4'h0);
        checkOutput("over_start_winner",  {2'b00, winner}, 4'h0);
        checkOutput("over_start_state",   {2'b00, gameState}, 4'h2);
        releaseButtons();
        p2Score = 4'd0;
        tick(10);
        checkOutput("m3_play", {2'b00, gameState}, 4'h1);

        for (int s = 1; s <= 2; s++) begin
            p1Score = 4'(s);
            p2Score = 4'(s);
            tick(1);
            checkOutput($sformatf("both_pt_%0d", s), {2'b00, p1Point, p2Point}, 4'h3);
            checkOutput($sformatf("both_state_%0d", s), {2'b00, gameState}, 4'h2);
            tick(10);
        end
        p1Score = 4'd3;
        p2Score = 4'd3;
        tick(1);
        checkOutput("tie_state",  {2'b00, gameState}, 4'h3);
        checkOutput("tie_winner", {2'b00, winner}, 4'h3);

        applyStimulus(1'b0);
        checkOutput("m4_state", {2'b00, gameState}, 4'h2);
        releaseButtons();
        p1Score = 4'd0;
        p2Score = 4'd0;
        tick(10);
        checkOutput("m4_play", {2'b00, gameState}, 4'h1);

        btnPause = 1'b1;
        tick(6);
        p1Score = 4'd1;
        tick(1);
        checkOutput("coinc_state",  {2'b00, gameState}, 4'h2);
        checkOutput("coinc_paused", {3'b000, paused}, 4'h0);
        checkOutput("coinc_point",  {3'b000, p1Point}, 4'h1);
        releaseButtons();
        tick(10);
        checkOutput("coinc_play",   {2'b00, gameState}, 4'h1);
        checkOutput("coinc_nopause", {3'b000, paused}, 4'h0);

        p1Score = 4'd2;
        tick(1);
        checkOutput("midserve_state", {2'b00, gameState}, 4'h2);
        tick(3);
        reset = 1'b0;
        tick(1);
        checkOutput("midrst_state",   {2'b00, gameState}, 4'h0);
        checkOutput("midrst_winner",  {2'b00, winner}, 4'h0);
        checkOutput("midrst_ballrst", {3'b000, ballRstN}, 4'h1);
        checkOutput("midrst_pulses",  {1'b0, paused, p1Point, p2Point}, 4'h0);
        reset = 1'b1;
        tick(12);
        checkOutput("postrst_idle", {2'b00, gameState}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
